// File: rtl/uart_pkg.sv
// Shared types and UART timing constants for the transmit scheduler.
// The default timeout must cover one full 11-bit frame at the default baud rate.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } sched_state_t;

    localparam int CLK_VALUE       = 50_000_000;
    localparam int BAUD            = 115_200;
    localparam int BIT_CYCLES      = CLK_VALUE / BAUD + 1;
    localparam int FRAME_BITS      = 11;
    localparam int FRAME_CYCLES    = FRAME_BITS * BIT_CYCLES;
    localparam int DEFAULT_TIMEOUT = 20_000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts one past last_grant and wraps around the request vector.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        sum       = '0;
        idx       = '0;
        found     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
        if (!enable) begin
            grant = '0;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers.
//   state     | meaning
//   IDLE      | waiting for a request; grants and captures the byte in the same cycle
//   ISSUE     | one-cycle start pulse to the transmitter
//   WAIT_DONE | waiting for txdone or the timeout
//   GAP       | forced idle time between frames (at least one cycle)
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter  int GAP_CYCLES     = 16,
    parameter  int CNT_W          = 16,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_start,
    output logic [7:0]           uart_data,
    input  logic                 uart_txdone,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     frame_count
);

    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_LEN = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GAP_W   = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

    sched_state_t       state;
    sched_state_t       state_next;
    logic [TO_W-1:0]    to_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [IDX_W-1:0]   last_grant;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               arb_en;
    logic               do_grant;
    logic               frame_done;
    logic [7:0]         data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[8*i +: 8];
    end

    assign arb_en = (state == IDLE) && !rst;
    assign busy   = (state != IDLE);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .enable     (arb_en),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any_req    (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_ready   = '0;
        uart_start  = 1'b0;
        timeout_err = 1'b0;
        do_grant    = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    do_grant   = 1'b1;
                    req_ready  = arb_grant;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                uart_start = 1'b1;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                // txdone on the final count still counts as a completed frame
                if (uart_txdone) begin
                    frame_done = 1'b1;
                    state_next = GAP;
                end else if (to_cnt == TO_LAST) begin
                    timeout_err = 1'b1;
                    state_next  = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            state_next  = IDLE;
            req_ready   = '0;
            uart_start  = 1'b0;
            timeout_err = 1'b0;
            do_grant    = 1'b0;
            frame_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uart_data   <= '0;
            grant_id    <= '0;
            last_grant  <= IDX_W'(NUM_REQ - 1);
            frame_count <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
        end else begin
            if (do_grant) begin
                uart_data  <= data_arr[arb_idx];
                grant_id   <= arb_idx;
                last_grant <= arb_idx;
            end
            if (frame_done) begin
                frame_count <= frame_count + CNT_W'(1);
            end
            if (state == ISSUE) begin
                to_cnt <= '0;
            end else if (state == WAIT_DONE) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (state == WAIT_DONE) begin
                gap_cnt <= '0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: a transaction-level timeline model predicts grants, frame ends and
// counter values; a negedge monitor compares every cycle against the queued expectations.
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int T  = 100;
    localparam int G  = 16;
    localparam int CW = 6;
    localparam int GL = (G < 1) ? 1 : G;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [8*N-1:0]  req_data = '0;
    logic [N-1:0]    req_ready;
    logic            uart_start;
    logic [7:0]      uart_data;
    logic            uart_txdone = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_err;
    logic [CW-1:0]   frame_count;

    uart_tx_scheduler #(
        .NUM_REQ(N), .TIMEOUT_CYCLES(T), .GAP_CYCLES(G), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .uart_start(uart_start), .uart_data(uart_data),
        .uart_txdone(uart_txdone), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int id; int data;} start_t;
    typedef struct {int cyc; int val;} fc_t;
    typedef struct {int lo; int hi;} span_t;

    start_t start_q[$];
    int     to_q[$];
    fc_t    fc_q[$];
    span_t  busy_q[$];
    int     zero_q[$];
    int     arr_q[N][$];
    int     dat_q[N][$];
    int     dptr[N];
    int     mptr[N];
    bit     tx_at[int];

    int cyc = 0, total = 0, bad = 0;
    int mlast = N - 1, mfc = 0, free_at = 4, ms = 0, me = 0, rst_until = 3, mode = 0;
    bit reset_req = 1'b0;
    logic [N-1:0] acc = '0;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void add_item(int r, int a, int d);
        arr_q[r].push_back(a);
        dat_q[r].push_back(d);
    endfunction

    // Timeline model: frames occupy grant+1 .. end+gap, then the scheduler is free again.
    task automatic model_step();
        logic [N-1:0] mv;
        int g, d, r;
        start_t st;
        fc_t f;
        span_t sp;
        if (reset_req && cyc == ms + 3 && cyc <= me) begin
            while (start_q.size() > 0 && start_q[$].cyc >= cyc) void'(start_q.pop_back());
            while (to_q.size() > 0 && to_q[$] >= cyc) void'(to_q.pop_back());
            while (fc_q.size() > 0 && fc_q[$].cyc >= cyc) void'(fc_q.pop_back());
            if (busy_q.size() > 0) begin
                sp = busy_q.pop_back();
                if (sp.hi > cyc) sp.hi = cyc;
                busy_q.push_back(sp);
            end
            for (int k = cyc; k <= me + GL; k++) if (tx_at.exists(k)) tx_at.delete(k);
            tx_at[cyc + 7] = 1'b1;
            rst_until = cyc + 1;
            mfc = 0;
            f.cyc = cyc + 1; f.val = 0; fc_q.push_back(f);
            zero_q.push_back(cyc + 1);
            mlast = N - 1;
            free_at = cyc + 2;
            reset_req = 1'b0;
            return;
        end
        if (cyc < free_at) return;
        mv = '0;
        for (int i = 0; i < N; i++)
            if (mptr[i] < arr_q[i].size() && arr_q[i][mptr[i]] <= cyc) mv[i] = 1'b1;
        if (mv == '0) begin
            if ($urandom_range(0, 19) == 0) tx_at[cyc] = 1'b1;
            return;
        end
        g = -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (mlast + k) % N;
            if (g < 0 && mv[j]) g = j;
        end
        ms = cyc + 1;
        st.cyc = ms; st.id = g; st.data = dat_q[g][mptr[g]];
        start_q.push_back(st);
        mptr[g]++;
        mlast = g;
        r = $urandom_range(0, 9);
        case (mode)
            1: d = 50;
            2: d = 0;
            3: d = T;
            default: d = (r == 0) ? 0 : (r == 1) ? T : int'($urandom_range(1, 60));
        endcase
        if (d > 0) begin
            me = ms + d;
            tx_at[me] = 1'b1;
            mfc = (mfc + 1) % (1 << CW);
            f.cyc = me + 1; f.val = mfc; fc_q.push_back(f);
        end else begin
            me = ms + T;
            to_q.push_back(me);
        end
        sp.lo = cyc + 1; sp.hi = me + GL;
        busy_q.push_back(sp);
        free_at = me + GL + 1;
        if ($urandom_range(0, 2) == 0) begin
            r = $urandom_range(0, GL);
            tx_at[(r == 0) ? ms : me + r] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (acc[i]) dptr[i]++;
        model_step();
        rst = (cyc <= rst_until);
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (dptr[i] < arr_q[i].size()) && (arr_q[i][dptr[i]] <= cyc);
            req_data[8*i +: 8] = req_valid[i] ? 8'(dat_q[i][dptr[i]]) : 8'(cyc ^ (i * 37));
        end
        uart_txdone = tx_at.exists(cyc);
        @(negedge clk);
        acc = req_valid & req_ready;
    endtask

    function automatic bit drained();
        for (int i = 0; i < N; i++)
            if (mptr[i] != arr_q[i].size() || dptr[i] != arr_q[i].size()) return 1'b0;
        return !reset_req && (cyc > free_at + 2);
    endfunction

    task automatic run_phase(int limit);
        int n = 0;
        bit done = 1'b0;
        do begin
            tick();
            n++;
            done = drained();
        end while (!done && n < limit);
        if (!done) chk("phase_drain", 0, 1);
    endtask

    initial begin : monitor
        int exp_data = 0, exp_id = 0, fc_exp = 0;
        bit st_exp, to_exp, busy_exp;
        fc_t f;
        forever begin
            @(negedge clk);
            if (cyc >= 2) begin
                while (zero_q.size() > 0 && zero_q[0] <= cyc) begin
                    if (zero_q[0] == cyc) begin
                        exp_data = 0;
                        exp_id = 0;
                        chk("ready_after_reset", int'(req_ready), 0);
                    end
                    void'(zero_q.pop_front());
                end
                while (start_q.size() > 0 && start_q[0].cyc < cyc) begin
                    chk("start_missing", 0, 1);
                    void'(start_q.pop_front());
                end
                st_exp = (start_q.size() > 0) && (start_q[0].cyc == cyc);
                if (uart_start || st_exp) begin
                    chk("uart_start", int'(uart_start), int'(st_exp));
                    if (st_exp) begin
                        exp_data = start_q[0].data;
                        exp_id = start_q[0].id;
                        void'(start_q.pop_front());
                    end
                end
                chk("uart_data", int'(uart_data), exp_data);
                chk("grant_id", int'(grant_id), exp_id);
                while (to_q.size() > 0 && to_q[0] < cyc) begin
                    chk("timeout_missing", 0, 1);
                    void'(to_q.pop_front());
                end
                to_exp = (to_q.size() > 0) && (to_q[0] == cyc);
                if (timeout_err || to_exp) begin
                    chk("timeout_err", int'(timeout_err), int'(to_exp));
                    if (to_exp) void'(to_q.pop_front());
                end
                while (fc_q.size() > 0 && fc_q[0].cyc <= cyc) begin
                    f = fc_q.pop_front();
                    fc_exp = f.val;
                end
                chk("frame_count", int'(frame_count), fc_exp);
                while (busy_q.size() > 0 && busy_q[0].hi < cyc) void'(busy_q.pop_front());
                busy_exp = (busy_q.size() > 0) && (busy_q[0].lo <= cyc);
                chk("busy", int'(busy), int'(busy_exp));
                if (req_ready != '0) chk("ready_while_busy", int'(busy), 0);
            end
        end
    end

    initial begin : stimulus
        int p, a;
        for (int i = 0; i < N; i++) begin
            dptr[i] = 0;
            mptr[i] = 0;
        end
        run_phase(50);
        // all four requesters contend, requester 0 has a second byte
        mode = 1;
        for (int i = 0; i < N; i++) add_item(i, cyc + 2, 8'h10 + i);
        add_item(0, cyc + 2, 8'h14);
        run_phase(2000);
        // single request on requester 2
        add_item(2, cyc + 3, 8'hA5);
        run_phase(500);
        // pure timeout
        mode = 2;
        add_item(1, cyc + 2, 8'h3C);
        run_phase(500);
        // txdone on the final timeout cycle
        mode = 3;
        add_item(3, cyc + 2, 8'hC3);
        run_phase(500);
        // reset during WAIT_DONE, stray txdone afterwards, priority restarts at 0
        mode = 2;
        reset_req = 1'b1;
        p = cyc;
        add_item(2, p + 1, 8'h5A);
        for (int i = 0; i < N; i++) add_item(i, p + 30, 8'h30 + i);
        run_phase(2000);
        // random contention long enough to wrap the frame counter
        mode = 0;
        for (int i = 0; i < N; i++) begin
            a = cyc + 2;
            for (int k = 0; k < 35; k++) begin
                a += $urandom_range(0, 450);
                add_item(i, a, $urandom_range(0, 255));
            end
        end
        run_phase(60000);
        chk("leftover_expect", start_q.size() + to_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
